dem_dwa_encoder: RTL and testbench

Parametrised dynamic-element-matching encoder driving the MSB (hi) and LSB (lo) current-steering cell arrays of the segmented DAC. It converts per-segment unary codes into cell-select vectors using data-weighted averaging (DWA) rotation, static thermometer mapping, or a built-in symmetric ramp pattern generator. Sits between the digital code source and the analog CS cell switches.

---
 rtl/dem_dwa_encoder.sv | 156 +++++++++++++++
 tb/tb_dem_dwa_encoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dem_dwa_encoder.sv
// DEM encoder for the hi/lo current-steering cell arrays: static thermometer, DWA rotation or ramp pattern.
// Optional build macro DEM_DITHER_EN adds an LFSR that occasionally bumps the rotation pointers by one cell.
module dem_dwa_encoder #(
  parameter int CELLS      = 10,
  parameter int CODE_W     = 4,
  parameter int STEPS      = 4,
  parameter int PAT_INC_HI = 3,
  parameter int PAT_INC_LO = 2
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_mode,
  input  logic              i_dem_dis,
  input  logic              i_valid,
  input  logic [CODE_W-1:0] i_code_hi,
  input  logic [CODE_W-1:0] i_code_lo,
  output logic              o_valid,
  output logic [CELLS-1:0]  o_cs_cell_hi,
  output logic [CELLS-1:0]  o_cs_cell_lo,
  output logic              o_code_err,
  output logic [CODE_W-1:0] o_ptr_hi,
  output logic [CODE_W-1:0] o_ptr_lo
);

  localparam int K_MAX = 2 * STEPS + 1;
  localparam int K_W   = $clog2(K_MAX + 1);
  localparam logic [CODE_W-1:0] CELLS_C = CODE_W'(CELLS);
  localparam logic [CODE_W+1:0] CELLS_W = (CODE_W + 2)'(CELLS);
  localparam logic [K_W-1:0]    K_LAST  = K_W'(K_MAX);

  typedef enum logic [1:0] {
    MODE_STATIC     = 2'b00,
    MODE_DWA        = 2'b01,
    MODE_PAT        = 2'b10,
    MODE_STATIC_ALT = 2'b11
  } mode_e;

  mode_e             mode;
  logic [K_W-1:0]    pat_k;
  logic              pat_mode;
  logic              rot_mode;
  logic              accept;
  logic              code_err;
  logic              ptr_upd;
  logic              dith;
  int                level;
  logic [CODE_W-1:0] code_hi_sel;
  logic [CODE_W-1:0] code_lo_sel;
  logic [CODE_W-1:0] map_ptr_hi;
  logic [CODE_W-1:0] map_ptr_lo;
  logic [CELLS-1:0]  hi_map;
  logic [CELLS-1:0]  lo_map;
  logic [CODE_W-1:0] ptr_hi_nxt;
  logic [CODE_W-1:0] ptr_lo_nxt;

  assign mode = mode_e'(i_mode);

  function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] c);
    return (c > CELLS_C) ? CELLS_C : c;
  endfunction

  function automatic logic [CODE_W-1:0] pat_code(input int prod);
    return (prod > CELLS) ? CELLS_C : CODE_W'(prod);
  endfunction

  // Cell j is on when its distance past the pointer (mod CELLS) is below the code.
  function automatic logic [CELLS-1:0] map_cells(input logic [CODE_W-1:0] c,
                                                 input logic [CODE_W-1:0] p);
    logic [CELLS-1:0] v;
    int d;
    v = '0;
    for (int j = 0; j < CELLS; j++) begin
      d = j - int'(p);
      if (d < 0) d = d + CELLS;
      v[j] = (d < int'(c));
    end
    return v;
  endfunction

  // Sum can reach 2*CELLS with dither, hence two conditional wraps.
  function automatic logic [CODE_W-1:0] advance(input logic [CODE_W-1:0] p,
                                                input logic [CODE_W-1:0] c,
                                                input logic extra);
    logic [CODE_W+1:0] sum;
    sum = {2'b00, p} + {2'b00, c} + {{(CODE_W + 1){1'b0}}, extra};
    if (sum >= CELLS_W) sum = sum - CELLS_W;
    if (sum >= CELLS_W) sum = sum - CELLS_W;
    return sum[CODE_W-1:0];
  endfunction

`ifdef DEM_DITHER_EN
  logic [6:0] lfsr;

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) lfsr <= 7'h5A;
    else         lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end

  assign dith = lfsr[0];
`else
  assign dith = 1'b0;
`endif

  always_comb begin
    pat_mode = (mode == MODE_PAT);
    rot_mode = pat_mode || (mode == MODE_DWA);
    accept   = pat_mode || i_valid;
    code_err = !pat_mode && i_valid && ((i_code_hi > CELLS_C) || (i_code_lo > CELLS_C));
    ptr_upd  = accept && rot_mode && !i_dem_dis;

    level = (int'(pat_k) <= STEPS) ? int'(pat_k) : (K_MAX - int'(pat_k));

    if (pat_mode) begin
      code_hi_sel = pat_code(level * PAT_INC_HI);
      code_lo_sel = pat_code(level * PAT_INC_LO);
    end else begin
      code_hi_sel = clamp_code(i_code_hi);
      code_lo_sel = clamp_code(i_code_lo);
    end

    map_ptr_hi = rot_mode ? o_ptr_hi : '0;
    map_ptr_lo = rot_mode ? o_ptr_lo : '0;
    hi_map     = map_cells(code_hi_sel, map_ptr_hi);
    lo_map     = map_cells(code_lo_sel, map_ptr_lo);
    ptr_hi_nxt = advance(o_ptr_hi, code_hi_sel, dith);
    ptr_lo_nxt = advance(o_ptr_lo, code_lo_sel, dith);
  end

  // Pattern index sits at 0 outside pattern mode, so entry always starts at level 0.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid      <= 1'b0;
      o_code_err   <= 1'b0;
      o_cs_cell_hi <= '0;
      o_cs_cell_lo <= '0;
      o_ptr_hi     <= '0;
      o_ptr_lo     <= '0;
      pat_k        <= '0;
    end else begin
      o_valid    <= accept;
      o_code_err <= code_err;
      if (accept) begin
        o_cs_cell_hi <= hi_map;
        o_cs_cell_lo <= lo_map;
      end
      if (ptr_upd) begin
        o_ptr_hi <= ptr_hi_nxt;
        o_ptr_lo <= ptr_lo_nxt;
      end
      if (!pat_mode)            pat_k <= '0;
      else if (pat_k == K_LAST) pat_k <= '0;
      else                      pat_k <= pat_k + 1'b1;
    end
  end

endmodule

// File: tb/tb_dem_dwa_encoder.sv
// Self-checking bench for dem_dwa_encoder: directed scenarios plus randomized traffic against a behavioural model.
module tb_dem_dwa_encoder;

  localparam int CELLS  = 10;
  localparam int CODE_W = 4;
  localparam int STEPS  = 4;
  localparam int INC_HI = 3;
  localparam int INC_LO = 2;
  localparam int PERIOD = 2 * STEPS + 2;

  logic              clk;
  logic              rst;
  logic [1:0]        mode;
  logic              dem_dis;
  logic              valid;
  logic [CODE_W-1:0] code_hi;
  logic [CODE_W-1:0] code_lo;
  logic              o_valid;
  logic [CELLS-1:0]  o_cs_cell_hi;
  logic [CELLS-1:0]  o_cs_cell_lo;
  logic              o_code_err;
  logic [CODE_W-1:0] o_ptr_hi;
  logic [CODE_W-1:0] o_ptr_lo;

  int n_checks = 0;
  int n_pass   = 0;

  int               m_ptr_hi, m_ptr_lo, m_k;
  logic             m_prev_pat, m_valid, m_err;
  logic [CELLS-1:0] m_hi, m_lo;

  int hi_tab [PERIOD] = '{0, 3, 6, 9, 10, 10, 9, 6, 3, 0};
  int lo_tab [PERIOD] = '{0, 2, 4, 6, 8, 8, 6, 4, 2, 0};

  dem_dwa_encoder #(
    .CELLS(CELLS), .CODE_W(CODE_W), .STEPS(STEPS),
    .PAT_INC_HI(INC_HI), .PAT_INC_LO(INC_LO)
  ) dut (
    .i_sys_clk(clk), .i_reset(rst), .i_mode(mode), .i_dem_dis(dem_dis),
    .i_valid(valid), .i_code_hi(code_hi), .i_code_lo(code_lo),
    .o_valid(o_valid), .o_cs_cell_hi(o_cs_cell_hi), .o_cs_cell_lo(o_cs_cell_lo),
    .o_code_err(o_code_err), .o_ptr_hi(o_ptr_hi), .o_ptr_lo(o_ptr_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CELLS-1:0] ref_map(input int c, input int p);
    logic [CELLS-1:0] v;
    v = '0;
    for (int j = 0; j < CELLS; j++)
      if ((((j - p) % CELLS) + CELLS) % CELLS < c) v[j] = 1'b1;
    return v;
  endfunction

  function automatic logic [CELLS-1:0] thermo(input int c);
    logic [CELLS:0] t;
    t = (11'(1) << c) - 11'(1);
    return t[CELLS-1:0];
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [29:0] obs_vec();
    return {o_valid, o_code_err, o_ptr_hi, o_ptr_lo, o_cs_cell_hi, o_cs_cell_lo};
  endfunction

  function automatic logic [29:0] exp_vec();
    return {m_valid, m_err, 4'(m_ptr_hi), 4'(m_ptr_lo), m_hi, m_lo};
  endfunction

  task automatic model_reset();
    m_ptr_hi = 0; m_ptr_lo = 0; m_k = 0; m_prev_pat = 1'b0;
    m_valid = 1'b0; m_err = 1'b0; m_hi = '0; m_lo = '0;
  endtask

  // Predicts the registered outputs after one clock edge from the inputs present at that edge.
  task automatic model_step();
    int  ch, cl, k, lvl;
    logic pat, rot, acc;
    pat = (mode == 2'b10);
    rot = pat || (mode == 2'b01);
    if (pat) begin
      k   = m_prev_pat ? m_k : 0;
      lvl = (k <= STEPS) ? k : (2 * STEPS + 1 - k);
      ch  = min_i(lvl * INC_HI, CELLS);
      cl  = min_i(lvl * INC_LO, CELLS);
      acc = 1'b1;
      m_err = 1'b0;
      m_k = (k + 1) % PERIOD;
    end else begin
      ch  = min_i(int'(code_hi), CELLS);
      cl  = min_i(int'(code_lo), CELLS);
      acc = valid;
      m_err = valid && ((int'(code_hi) > CELLS) || (int'(code_lo) > CELLS));
    end
    if (acc) begin
      m_hi = ref_map(ch, rot ? m_ptr_hi : 0);
      m_lo = ref_map(cl, rot ? m_ptr_lo : 0);
      if (rot && !dem_dis) begin
        m_ptr_hi = (m_ptr_hi + ch) % CELLS;
        m_ptr_lo = (m_ptr_lo + cl) % CELLS;
      end
    end
    m_valid    = acc;
    m_prev_pat = pat;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b00; dem_dis = 1'b0; valid = 1'b0; code_hi = '0; code_lo = '0;
    model_reset();
    #12;
    n_checks++;
    if (obs_vec() !== 30'h0) $display("[TB] FAIL reset_state: got %h expected %h", obs_vec(), 30'h0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_static();
    mode = 2'b00; valid = 1'b1; code_hi = 4'd3; code_lo = 4'd7;
    tick();
    n_checks++;
    if ({o_valid, o_cs_cell_hi, o_cs_cell_lo, o_ptr_hi, o_ptr_lo} !== {1'b1, 10'b0000000111, 10'b0001111111, 8'h00})
      $display("[TB] FAIL static_3_7: got v=%b hi=%b lo=%b ptr=%h/%h expected v=1 hi=0000000111 lo=0001111111 ptr=0/0",
               o_valid, o_cs_cell_hi, o_cs_cell_lo, o_ptr_hi, o_ptr_lo);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      mode = (i % 2 == 0) ? 2'b11 : 2'b00;
      valid = 1'($urandom_range(0, 1));
      code_hi = 4'($urandom_range(0, CELLS)); code_lo = 4'($urandom_range(0, CELLS));
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("[TB] FAIL static_rand: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_dwa();
    do_reset();
    mode = 2'b01; valid = 1'b1; dem_dis = 1'b0; code_hi = 4'd3; code_lo = 4'd0;
    tick();
    n_checks++;
    if ({o_cs_cell_hi, o_ptr_hi} !== {10'b0000000111, 4'd3})
      $display("[TB] FAIL dwa_first: got hi=%b ptr=%0d expected hi=0000000111 ptr=3", o_cs_cell_hi, o_ptr_hi);
    else n_pass++;
    code_hi = 4'd9;
    tick();
    n_checks++;
    if ({o_cs_cell_hi, o_ptr_hi} !== {10'b1111111011, 4'd2})
      $display("[TB] FAIL dwa_second: got hi=%b ptr=%0d expected hi=1111111011 ptr=2", o_cs_cell_hi, o_ptr_hi);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      code_hi = 4'($urandom_range(0, CELLS)); code_lo = 4'($urandom_range(0, CELLS));
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("[TB] FAIL dwa_rand: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    logic [CODE_W-1:0] ptr_before;
    mode = 2'b01; valid = 1'b1; dem_dis = 1'b0; code_hi = 4'd12; code_lo = 4'd4;
    ptr_before = o_ptr_hi;
    tick();
    n_checks++;
    if ({o_code_err, o_cs_cell_hi, o_ptr_hi} !== {1'b1, 10'b1111111111, ptr_before})
      $display("[TB] FAIL sat_clamp: got err=%b hi=%b ptr=%0d expected err=1 hi=1111111111 ptr=%0d",
               o_code_err, o_cs_cell_hi, o_ptr_hi, ptr_before);
    else n_pass++;
    n_checks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL sat_model: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    code_hi = 4'd2; code_lo = 4'd1;
    tick();
    n_checks++;
    if (o_code_err !== 1'b0) $display("[TB] FAIL sat_pulse_end: got err=%b expected 0", o_code_err);
    else n_pass++;
    valid = 1'b0; code_hi = 4'd15; code_lo = 4'd15;
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec() || o_code_err !== 1'b0)
      $display("[TB] FAIL sat_not_accepted: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_pattern();
    do_reset();
    mode = 2'b10; dem_dis = 1'b1; valid = 1'b0; code_hi = 4'd15; code_lo = 4'd15;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick();
      n_checks++;
      if ({o_valid, o_code_err, o_ptr_hi, o_ptr_lo, o_cs_cell_hi, o_cs_cell_lo} !==
          {1'b1, 1'b0, 8'h00, thermo(hi_tab[i % PERIOD]), thermo(lo_tab[i % PERIOD])})
        $display("[TB] FAIL pattern_step%0d: got hi=%b lo=%b v=%b expected hi=%b lo=%b v=1",
                 i, o_cs_cell_hi, o_cs_cell_lo, o_valid, thermo(hi_tab[i % PERIOD]), thermo(lo_tab[i % PERIOD]));
      else n_pass++;
    end
    dem_dis = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("[TB] FAIL pattern_rot: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_dem_dis();
    do_reset();
    mode = 2'b01; valid = 1'b1; dem_dis = 1'b1; code_hi = 4'd5; code_lo = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({o_cs_cell_hi, o_cs_cell_lo, o_ptr_hi, o_ptr_lo} !== {10'b0000011111, 10'b0000011111, 8'h00})
        $display("[TB] FAIL dis_frozen: got hi=%b lo=%b ptr=%0d/%0d expected 0000011111 ptr 0/0",
                 o_cs_cell_hi, o_cs_cell_lo, o_ptr_hi, o_ptr_lo);
      else n_pass++;
    end
    dem_dis = 1'b0;
    tick();
    n_checks++;
    if ({o_cs_cell_hi, o_ptr_hi, o_ptr_lo} !== {10'b0000011111, 4'd5, 4'd5})
      $display("[TB] FAIL dis_release1: got hi=%b ptr=%0d/%0d expected hi=0000011111 ptr=5/5",
               o_cs_cell_hi, o_ptr_hi, o_ptr_lo);
    else n_pass++;
    tick();
    n_checks++;
    if ({o_cs_cell_hi, o_ptr_hi, o_ptr_lo} !== {10'b1111100000, 4'd0, 4'd0})
      $display("[TB] FAIL dis_release2: got hi=%b ptr=%0d/%0d expected hi=1111100000 ptr=0/0",
               o_cs_cell_hi, o_ptr_hi, o_ptr_lo);
    else n_pass++;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        mode = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 14);
      end
      hold--;
      dem_dis = ($urandom_range(0, 4) == 0);
      valid   = 1'($urandom_range(0, 1));
      code_hi = 4'($urandom_range(0, 15));
      code_lo = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("[TB] FAIL random_%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_pattern();
    do_reset();
    mode = 2'b10; dem_dis = 1'b0; valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== 30'h0) $display("[TB] FAIL mid_reset_async: got %h expected %h", obs_vec(), 30'h0);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if ({o_valid, o_cs_cell_hi, o_cs_cell_lo, o_ptr_hi, o_ptr_lo} !== {1'b1, 20'h0, 8'h00})
      $display("[TB] FAIL mid_reset_level0: got v=%b hi=%b lo=%b ptr=%0d/%0d expected v=1 all zero",
               o_valid, o_cs_cell_hi, o_cs_cell_lo, o_ptr_hi, o_ptr_lo);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("[TB] FAIL mid_reset_restart: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_dwa();
    test_saturation();
    test_pattern();
    test_dem_dis();
    test_random();
    test_reset_mid_pattern();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
